// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter: round-robin sharing of one multicycle signed multiplier among N_REQ requesters.
// Latency: req seen in IDLE -> req_ack + mul_start next cycle; rsp_valid one cycle after mul_done.
// Backpressure: requesters hold req/operands until req_ack; one multiply in flight; option MUL_TIMEOUT_EN.
module mul_share_arbiter #(
    parameter int N_REQ   = 2,
    parameter int DW      = 16,
    parameter int TIMEOUT = 31
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_a,
    input  logic [N_REQ*DW-1:0] req_b,
    output logic [N_REQ-1:0]    req_ack,
    output logic [N_REQ-1:0]    rsp_valid,
    output logic [DW-1:0]       rsp_result,
    output logic                rsp_err,
    output logic                busy,
    output logic                mul_start,
    output logic [DW-1:0]       mul_a,
    output logic [DW-1:0]       mul_b,
    input  logic [DW-1:0]       mul_result,
    input  logic                mul_done
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [N_REQ-1:0] ONE_HOT0 = 1;

    // Reject configurations the arbiter was not built for at elaboration time.
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("mul_share_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t        state;
    logic [PW-1:0] rr_ptr;
    logic [PW-1:0] grant;
    logic [PW-1:0] winner;
    logic [PW-1:0] next_ptr;
    logic          found;
    logic [DW-1:0] sel_a;
    logic [DW-1:0] sel_b;

`ifdef MUL_TIMEOUT_EN
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [TW-1:0] wait_cnt;
`endif

    // Wrap a requester index back into 0..N_REQ-1 (rr_ptr + offset never exceeds 2*N_REQ-2).
    function automatic int wrap_idx(input int v);
        return (v >= N_REQ) ? v - N_REQ : v;
    endfunction

    // Round-robin pick: first pending requester starting at rr_ptr, plus its operands.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        sel_a  = '0;
        sel_b  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            for (int j = 0; j < N_REQ; j++) begin
                if (!found && req[j] && (j == wrap_idx(int'(rr_ptr) + k))) begin
                    found  = 1'b1;
                    winner = PW'(j);
                    sel_a  = req_a[j*DW +: DW];
                    sel_b  = req_b[j*DW +: DW];
                end
            end
        end
    end

    // Pointer moves to the requester just after the one being answered.
    always_comb begin
        next_ptr = (grant == PW'(N_REQ - 1)) ? '0 : grant + 1'b1;
    end

    // Control FSM; every output is registered so pulses are clean single cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            grant      <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_result <= '0;
            req_ack    <= '0;
            rsp_valid  <= '0;
            mul_start  <= 1'b0;
            busy       <= 1'b0;
`ifdef MUL_TIMEOUT_EN
            rsp_err    <= 1'b0;
            wait_cnt   <= '0;
`endif
        end else begin
            req_ack   <= '0;
            rsp_valid <= '0;
            mul_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        mul_a     <= sel_a;
                        mul_b     <= sel_b;
                        grant     <= winner;
                        req_ack   <= ONE_HOT0 << winner;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef MUL_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // Operands stay untouched here: the multiplier samples sign bits at completion.
                    if (mul_done) begin
                        rsp_result <= mul_result;
`ifdef MUL_TIMEOUT_EN
                        rsp_err    <= 1'b0;
`endif
                        rsp_valid  <= ONE_HOT0 << grant;
                        state      <= S_RESP;
                    end
`ifdef MUL_TIMEOUT_EN
                    else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= ONE_HOT0 << grant;
                        state      <= S_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    rr_ptr <= next_ptr;
                    busy   <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifndef MUL_TIMEOUT_EN
    assign rsp_err = 1'b0;
`endif

endmodule
